// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and width limits.
package mult_pkg;

    localparam int MULT_WIDTH_MIN     = 2;
    localparam int MULT_WIDTH_MAX     = 32;
    localparam int MULT_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// Accumulator (H) and multiplier shift register (L) for the shift-add multiplier.
// One multiplier bit is retired per step strobe; result_next is the {H,L} value after this step.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 last_step,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result_next
);

    logic [WIDTH:0]   h_q;
    logic [WIDTH-1:0] l_q;
    logic [WIDTH-1:0] a_q;
    logic             sm_q;

    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   h_nxt;
    logic [WIDTH-1:0] l_nxt;

    always_comb begin
        ext_a = sm_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        sum   = h_q;
        // The multiplier MSB carries negative weight in two's complement.
        if (l_q[0]) begin
            sum = (last_step && sm_q) ? (h_q - ext_a) : (h_q + ext_a);
        end
        // Unsigned: the add carry sits in sum[WIDTH] and is shifted down; signed: arithmetic shift.
        h_nxt       = {sm_q & sum[WIDTH], sum[WIDTH:1]};
        l_nxt       = {sum[0], l_q[WIDTH-1:1]};
        result_next = {h_nxt[WIDTH-1:0], l_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q  <= '0;
            l_q  <= '0;
            a_q  <= '0;
            sm_q <= 1'b0;
        end else if (load) begin
            h_q  <= '0;
            l_q  <= multiplier;
            a_q  <= multiplicand;
            sm_q <= signed_mode;
        end else if (step) begin
            h_q  <= h_nxt;
            l_q  <= l_nxt;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Handshake: start is accepted only in IDLE with clr low; busy is high while running; done pulses one cycle with product valid.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic               last_step;
    logic [2*WIDTH-1:0] result_next;

    assign busy      = (state == ST_RUN);
    assign load      = (state == ST_IDLE) && start && !clr;
    assign step      = (state == ST_RUN) && !clr;
    assign last_step = step && (cnt == LAST_CNT);

    shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .last_step    (last_step),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result_next  (result_next)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (last_step) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        done    <= 1'b1;
                        product <= result_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: arithmetic reference model checked every cycle, plus directed literal cases.
module tb_shift_add_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    logic           clr16 = 1'b0;
    logic           start16 = 1'b0;
    logic           sm16 = 1'b0;
    logic [15:0]    a16 = '0;
    logic [15:0]    b16 = '0;
    logic           busy16;
    logic           done16;
    logic [31:0]    product16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    shift_add_mult #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr16),
        .start        (start16),
        .signed_mode  (sm16),
        .multiplicand (a16),
        .multiplier   (b16),
        .busy         (busy16),
        .done         (done16),
        .product      (product16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sm);
        int ia;
        int ib;
        int p;
        ia = sm ? int'($signed(a)) : int'(a);
        ib = sm ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p[2*W-1:0];
    endfunction

    // Reference model: operation timing as seen at the ports, result from plain arithmetic.
    logic           m_valid = 1'b0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;
    int             m_left = 0;

    always @(posedge clk) begin
        if (rst || clr) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_left <= 0;
            if (rst) m_valid <= 1'b1;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_prod <= m_pend;
            end
            m_left <= m_left - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_left <= W;
                m_pend <= ref_mult(multiplicand, multiplier, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_busy", 64'(busy), 64'(m_busy));
            check("model_done", 64'(done), 64'(m_done));
            check("model_product", 64'(product), 64'(m_prod));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with the given operands, then measure latency to done and pin the product.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [2*W-1:0] exp, input string name);
        int n;
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(W));
        check({name, "_product"}, 64'(product), 64'(exp));
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        tick();
        check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int first_done;
        int second_done;
        logic saw_done;

        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst = 1'b0;
        tick();

        do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3_5");
        do_op(8'hFD, 8'h05, 1'b0, 16'h04F1, "u_fd_5");
        do_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
        do_op(8'h80, 8'h7F, 1'b1, 16'hC080, "s_80_7f");
        do_op(8'h00, 8'hA5, 1'b1, 16'h0000, "s_zero");

        // Start held high: back-to-back results every W+1 cycles.
        multiplicand = 8'd3;
        multiplier   = 8'd4;
        signed_mode  = 1'b0;
        start        = 1'b1;
        tick();
        n = 1;
        first_done  = -1;
        second_done = -1;
        while (second_done < 0 && n < 60) begin
            if (done) begin
                check("held_product", 64'(product), 64'h000C);
                if (first_done < 0) first_done = n;
                else second_done = n;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("held_first_done", 64'(first_done), 64'(W + 1));
        check("held_second_done", 64'(second_done), 64'(2 * W + 2));
        repeat (W + 2) tick();

        // clr during RUN discards the operation.
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_product", 64'(product), 64'd0);
        saw_done = 1'b0;
        repeat (W + 2) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("clr_no_done", 64'(saw_done), 64'd0);

        // clr and start together in IDLE: not accepted.
        clr   = 1'b1;
        start = 1'b1;
        tick();
        clr   = 1'b0;
        start = 1'b0;
        check("clr_start_no_accept", 64'(busy), 64'd0);

        // rst mid-run after a completed operation.
        do_op(8'h12, 8'h34, 1'b0, 16'h03A8, "u_12_34");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);

        // WIDTH=16 instance.
        a16     = 16'hFFFF;
        b16     = 16'hFFFF;
        sm16    = 1'b0;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 60) begin
            tick();
            n++;
        end
        check("w16_latency", 64'(n), 64'd16);
        check("w16_product", 64'(product16), 64'hFFFE0001);

        // Random traffic: starts while busy, operand churn mid-run and occasional clr.
        for (int i = 0; i < 600; i++) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            signed_mode  = 1'($urandom);
            start        = ($urandom_range(0, 3) == 0);
            clr          = ($urandom_range(0, 60) == 0);
            tick();
        end
        start = 1'b0;
        clr   = 1'b0;
        repeat (W + 3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-add multiplier core that replaces the fixed 8-bit datapath behind the board top level. It adds a start/busy/done handshake and a runtime signed/unsigned mode. It accepts two WIDTH-bit operands and returns a 2*WIDTH-bit product after WIDTH iterations, retiring one multiplier bit per clock. It sits between the operand registers and the 7-segment display driver, on the divided system clock.

## Interface
- WIDTH, default 8: operand width; legal range 2..32. Product width is 2*WIDTH.
- CNT_W, default $clog2(WIDTH): derived localparam, width of the iteration counter. Not overridable.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high; highest priority.
- clr  in  1  synchronous abort/clear, active-high; priority below rst, above start.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- multiplicand  in  WIDTH  operand A; captured on the accepting edge.
- multiplier  in  WIDTH  operand B; captured on the accepting edge.
- busy  out  1  high while the state is RUN.
- done  out  1  one-cycle completion pulse.
- product  out  2*WIDTH  registered result; holds until the next completion, clr or rst.

## Operation
- States: IDLE and RUN.
- IDLE -> RUN when start=1 and clr=0. On that edge: capture A, B and signed_mode; iteration counter = 0; H = 0 (WIDTH+1 bits); L = B.
- Each RUN cycle, step i = 0..WIDTH-1:
  - if L[0] = 1, H = H + ext(A), where ext is a sign-extension when signed_mode=1 and a zero-extension otherwise.
  - Exception: on step WIDTH-1 with signed_mode=1, H = H - ext(A) (multiplier MSB has negative weight).
  - Then {H,L} shifts right 1. The shift is arithmetic on H[WIDTH] when signed_mode=1; when unsigned, the add carry lands in H[WIDTH] and is shifted in.
- RUN -> IDLE on the edge completing step WIDTH-1. On that edge: product = {H[WIDTH-1:0], L}, done = 1.
- Result: the exact 2*WIDTH-bit product; no overflow is possible in either mode.
- start while busy is ignored; no queueing.
- Operand or signed_mode changes during RUN have no effect.
- clr (any state): state = IDLE, busy = 0, done = 0, product = 0, counter = 0. An in-flight operation is discarded with no done pulse.
- clr and start in the same cycle: clr wins, and start is not accepted.
- rst: same effect as clr; also clears all internal H/L/operand registers to 0.

## Timing
- Reset values: busy = 0, done = 0, product = 0, state = IDLE.
- Start accepted at edge E0. busy is high from after E0 through edge E0+WIDTH.
- At edge E0+WIDTH: busy falls, done rises and stays high for exactly one cycle, and product updates.
- Latency is WIDTH cycles start-to-done. Throughput is one result per WIDTH+1 cycles when start is held high: start is re-sampled in the done cycle, which is IDLE, so the next accept occurs at edge E0+WIDTH+1.
- product never changes mid-run; it reflects the last completed operation.
- rst or clr asserted during RUN takes effect on that same edge.

## Structure
- Shared package mult_pkg holds:
  - the state typedef (ST_IDLE, ST_RUN);
  - the WIDTH range limits (MULT_WIDTH_MIN=2, MULT_WIDTH_MAX=32);
  - the default width constant MULT_WIDTH_DEFAULT=8.
- Natural sub-module: shift_add_datapath. It contains the H/L registers, the add/subtract and the shift, driven by load, step and last_step strobes from the FSM.
- The FSM and counter stay in the top module.

## Test plan
- WIDTH=8, unsigned, A=0xFF, B=0xFF, start pulse -> busy high for 8 cycles, done at edge E0+8, product = 0xFE01.
- WIDTH=8, signed, A=0xFD (-3), B=0x05 -> product 0xFFF1 (-15). Same operands unsigned -> 0x04F1 (1265).
- WIDTH=8, signed, A=0x80, B=0x80 -> product 0x4000. Then A=0x80, B=0x7F -> product 0xC080 (-16256).
- Start held high continuously, A=3, B=4 -> done pulses at E0+8 and E0+17, product = 0x000C each time; start asserted mid-run is ignored.
- clr asserted at RUN cycle 4 -> busy = 0 and product = 0 at the next cycle, no done pulse. clr and start together in IDLE -> no accept. rst mid-run -> all outputs 0.
- WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF -> product 0xFFFE0001, done exactly 16 cycles after accept.
